umi_unpack: RTL and testbench

UMI_UNPACK -- requirements
Module: umi_unpack

---
 rtl/umi_unpack_if.sv | 45 ++++
 rtl/umi_unpack.sv | 138 +++++++++++++
 tb/tb_umi_unpack.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/umi_unpack_if.sv
//------------------------------------------------------------------------------
// umi_unpack_if
// Packet-in / fields-out handshake bundle for the UMI unpacker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface umi_unpack_if #(
  parameter int AW = 64,
  parameter int UW = 256
);
  // Upstream packet channel
  logic          in_valid;
  logic [UW-1:0] in_packet;
  logic          in_ready;

  // Downstream field channel
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_opcode;
  logic [3:0]      out_size;
  logic [19:0]     out_user;
  logic [AW-1:0]   out_dstaddr;
  logic [AW-1:0]   out_srcaddr;
  logic [4*AW-1:0] out_data;
  logic            out_read;
  logic            out_burst;
  logic            out_last;

  // Packet source / field sink side
  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_opcode, out_size, out_user, out_dstaddr,
           out_srcaddr, out_data, out_read, out_burst, out_last
  );

  // Unpacker side
  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_opcode, out_size, out_user, out_dstaddr,
           out_srcaddr, out_data, out_read, out_burst, out_last
  );
endinterface

`default_nettype wire

// File: rtl/umi_unpack.sv
//------------------------------------------------------------------------------
// umi_unpack
// Splits UMI header packets into command fields and follows write bursts,
// un-rotating data beats and generating per-beat destination addresses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module umi_unpack #(
  parameter int AW = 64,
  parameter int UW = 256
) (
  input  logic         clk,
  input  logic         reset,
  umi_unpack_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_HDR   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [4:0]    c_read_cmd       = 5'h01;
  localparam logic [3:0]    c_burst_min_size = 4'd5;
  localparam logic [AW-1:0] c_first_beat_ofs = AW'(16);
  localparam logic [AW-1:0] c_beat_stride    = AW'(32);

  state_t          r_state;
  logic [10:0]     r_count;
  logic [AW-1:0]   r_beat_addr;
  logic            r_out_valid;
  logic [7:0]      r_opcode;
  logic [3:0]      r_size;
  logic [19:0]     r_user;
  logic [AW-1:0]   r_dstaddr;
  logic [AW-1:0]   r_srcaddr;
  logic [4*AW-1:0] r_data;
  logic            r_read;
  logic            r_burst;
  logic            r_last;

  logic [UW-1:0]   w_pkt;
  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_hdr_read;
  logic [3:0]      w_hdr_size;
  logic [3:0]      w_beat_shift;
  logic [AW-1:0]   w_hdr_dstaddr;
  logic            w_burst_follows;
  logic [10:0]     w_beat_count;

  assign w_pkt      = bus.in_packet;
  // Output register may be refilled when empty or draining this cycle
  assign w_in_ready = !r_out_valid | bus.out_ready;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  assign w_hdr_read      = (w_pkt[4:0] == c_read_cmd);
  assign w_hdr_size      = w_pkt[11:8];
  assign w_hdr_dstaddr   = {w_pkt[255:224], w_pkt[63:32]};
  assign w_burst_follows = !w_hdr_read && (w_hdr_size >= c_burst_min_size);
  assign w_beat_shift    = w_hdr_size - c_burst_min_size;
  assign w_beat_count    = 11'd1 << w_beat_shift;

  // Header/burst FSM with the single registered output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HDR;
      r_count     <= '0;
      r_beat_addr <= '0;
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_size      <= '0;
      r_user      <= '0;
      r_dstaddr   <= '0;
      r_srcaddr   <= '0;
      r_data      <= '0;
      r_read      <= 1'b0;
      r_burst     <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      if (r_state == ST_HDR) begin
        r_opcode  <= w_pkt[7:0];
        r_size    <= w_hdr_size;
        r_user    <= w_pkt[31:12];
        r_dstaddr <= w_hdr_dstaddr;
        r_read    <= w_hdr_read;
        r_burst   <= 1'b0;
        if (w_hdr_read) begin
          r_srcaddr <= {w_pkt[223:192], w_pkt[95:64]};
          r_data    <= '0;
        end else begin
          // Writes carry only the low source word; upper bits hold payload
          r_srcaddr <= {32'h0, w_pkt[95:64]};
          r_data    <= {128'h0, w_pkt[223:96]};
        end
        if (w_burst_follows) begin
          r_count     <= w_beat_count;
          r_beat_addr <= w_hdr_dstaddr + c_first_beat_ofs;
          r_last      <= 1'b0;
          r_state     <= ST_BURST;
        end else begin
          r_last <= 1'b1;
        end
      end else begin
        // Data beat: command fields stay as loaded by the header
        r_dstaddr   <= r_beat_addr;
        r_beat_addr <= r_beat_addr + c_beat_stride;
        r_data      <= {w_pkt[95:0], w_pkt[255:96]};
        r_burst     <= 1'b1;
        r_count     <= r_count - 11'd1;
        if (r_count == 11'd1) begin
          r_last  <= 1'b1;
          r_state <= ST_HDR;
        end else begin
          r_last <= 1'b0;
        end
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_opcode  = r_opcode;
  assign bus.out_size    = r_size;
  assign bus.out_user    = r_user;
  assign bus.out_dstaddr = r_dstaddr;
  assign bus.out_srcaddr = r_srcaddr;
  assign bus.out_data    = r_data;
  assign bus.out_read    = r_read;
  assign bus.out_burst   = r_burst;
  assign bus.out_last    = r_last;

endmodule

`default_nettype wire

// File: tb/tb_umi_unpack.sv
//------------------------------------------------------------------------------
// tb_umi_unpack
// Randomised bench for umi_unpack against a transaction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_umi_unpack;

  typedef struct packed {
    logic [7:0]   opcode;
    logic [3:0]   size;
    logic [19:0]  user;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
    logic         rd;
    logic         burst;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  umi_unpack_if #(.AW(64), .UW(256)) bus ();

  umi_unpack #(.AW(64), .UW(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  logic [255:0] inq[$];
  exp_t         expq[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t e;
    e.opcode = bus.out_opcode;
    e.size   = bus.out_size;
    e.user   = bus.out_user;
    e.dst    = bus.out_dstaddr;
    e.src    = bus.out_srcaddr;
    e.data   = bus.out_data;
    e.rd     = bus.out_read;
    e.burst  = bus.out_burst;
    e.last   = bus.out_last;
    return e;
  endfunction

  // Build the wire packets of one transaction and the outputs it must produce
  task automatic send_txn(input logic [7:0] op, input logic [3:0] size, input logic [19:0] user,
                          input logic [63:0] dst, input logic [63:0] src, input logic [127:0] pay);
    logic [255:0] p;
    exp_t         e;
    logic         rd;
    int           n;
    rd = (op[4:0] == 5'h01);
    p = '0;
    p[7:0]     = op;
    p[11:8]    = size;
    p[31:12]   = user;
    p[63:32]   = dst[31:0];
    p[255:224] = dst[63:32];
    p[95:64]   = src[31:0];
    if (rd) p[223:192] = src[63:32];
    else    p[223:96]  = pay;
    e.opcode = op;
    e.size   = size;
    e.user   = user;
    e.dst    = dst;
    e.rd     = rd;
    e.burst  = 1'b0;
    e.src    = rd ? src : {32'h0, src[31:0]};
    e.data   = rd ? 256'h0 : {128'h0, pay};
    n = (!rd && size >= 4'd5) ? (1 << (int'(size) - 5)) : 0;
    e.last = (n == 0);
    inq.push_back(p);
    expq.push_back(e);
    for (int k = 1; k <= n; k++) begin
      logic [255:0] d;
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      inq.push_back({d[159:0], d[255:160]});
      e.dst   = dst + 64'd16 + 64'(32 * (k - 1));
      e.data  = d;
      e.burst = 1'b1;
      e.last  = (k == n);
      expq.push_back(e);
    end
  endtask

  // Drive queued packets with random throttling and score every visible output
  task automatic run(input int pv, input int pr, input int budget, input bit chk_drain);
    int cyc = 0;
    while ((inq.size() > 0 || expq.size() > 0) && cyc < budget) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(99) < pr);
      bus.in_valid  = (inq.size() > 0) && ($urandom_range(99) < pv);
      bus.in_packet = (inq.size() > 0) ? inq[0] : 256'h0;
      #1;
      if (bus.out_valid) begin
        if (expq.size() == 0) check("spurious", bus.out_valid, 0);
        else begin
          check("out", dut_out(), expq[0]);
          if (bus.out_ready) void'(expq.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) void'(inq.pop_front());
      cyc++;
    end
    if (chk_drain) check("drain", inq.size() + expq.size(), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] pay;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_fields", dut_out(), 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Read header: output exactly one cycle after acceptance
    send_txn(8'h01, 4'd3, 20'h12345, 64'h1_0000_0040, 64'h2_0000_0080, 128'h0);
    run(100, 100, 2, 1);

    // Write header size 4, payload bytes 0x00..0x0F
    for (int b = 0; b < 16; b++) pay[b*8 +: 8] = 8'(b);
    send_txn(8'h03, 4'd4, 20'h00abc, 64'h0000_0000_0000_2000, 64'h5555_6666_7777_8888, pay);
    run(100, 100, 2, 1);

    // Four-beat burst at full throughput, followed by a header
    send_txn(8'h03, 4'd7, 20'h00001, 64'h1000, 64'h42, {4{$urandom}});
    send_txn(8'h01, 4'd2, 20'h00002, 64'hdead_beef_0000_0010, 64'h0123_4567_89ab_cdef, 128'h0);
    run(100, 100, 7, 1);

    // Single-beat burst whose beat address wraps
    send_txn(8'h03, 4'd5, 20'h00003, 64'hFFFF_FFFF_FFFF_FFF8, 64'h9, {4{$urandom}});
    run(100, 100, 3, 1);

    // Random mix of transactions under throttling
    for (int t = 0; t < 30; t++)
      send_txn(($urandom_range(1) != 0) ? 8'h01 : 8'h03, 4'($urandom_range(8)),
               20'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {4{$urandom}});
    run(70, 60, 5000, 1);

    // 1024-beat burst under throttling
    send_txn(8'h03, 4'd15, 20'h0f00f, {$urandom, $urandom}, 64'h77, {4{$urandom}});
    run(60, 50, 20000, 1);

    // Reset after the second beat of a size-7 burst
    send_txn(8'h03, 4'd7, 20'h00004, 64'h4000, 64'h1, {4{$urandom}});
    run(100, 100, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", bus.out_valid, 0);
    check("rst_async_fields", dut_out(), 0);
    inq.delete();
    expq.delete();
    @(negedge clk);
    reset = 1'b0;
    send_txn(8'h01, 4'd1, 20'h00005, 64'h3_0000_0100, 64'h4_0000_0200, 128'h0);
    send_txn(8'h03, 4'd4, 20'h00006, 64'h5000, 64'h6, {4{$urandom}});
    run(100, 100, 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
